bp_update_scheduler: RTL
========================

Name: bp_update_scheduler

Overview:
Owns the single-port 2-bit-counter pattern table and the global history register (GHR) of the branch predictor. Fetch-stage lookups get the table port immediately. Branch outcomes resolved in execute are queued and applied as read-modify-write updates in idle port cycles. It sits between fetch/execute and the pattern-table SRAM, and replaces direct GHR/table manipulation in the datapath.

Parameters:
GHR_WIDTH, 8, history length; also the table address width (table depth = 1<<GHR_WIDTH)
FIFO_DEPTH, 4, number of pending resolved-branch updates (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
Fetch_Lookup  in  1  fetch requests a prediction this cycle
Br_PredictedBit  out  1  prediction (Tbl_RData[1]), valid when Pred_Valid=1
Pred_Valid  out  1  registered; high the cycle after an accepted Fetch_Lookup
Br_Dectected  in  1  a branch resolved in execute this cycle
Br_Comp_Result  in  1  resolved outcome, 1 = taken
Br_Index  in  GHR_WIDTH  table index used when this branch was predicted
Ghr  out  GHR_WIDTH  current global history
Tbl_En  out  1  table port enable
Tbl_We  out  1  table write enable
Tbl_Addr  out  GHR_WIDTH  table address
Tbl_WData  out  2  counter write data
Tbl_RData  in  2  table read data, 1-cycle latency after Tbl_En & !Tbl_We
Queue_Full  out  1  update FIFO holds FIFO_DEPTH entries
Upd_Drop  out  1  registered pulse: a resolved branch was discarded because the queue was full
Busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Reset: FSM=IDLE, FIFO count=0, Ghr=0, Pred_Valid=0, Upd_Drop=0, Tbl_* outputs low. A reset mid-update abandons that update; the table is left unchanged because no partial write is issued.
- GHR: on Br_Dectected, Ghr <= {Br_Comp_Result, Ghr[GHR_WIDTH-1:1]}. This happens regardless of FIFO state.
- Port priority: Fetch_Lookup=1 always wins. In that case Tbl_En=1, Tbl_We=0, Tbl_Addr=Ghr (the pre-update value in that cycle). Next cycle Pred_Valid=1 and Br_PredictedBit=Tbl_RData[1].
- FIFO: entry = {Br_Index, Br_Comp_Result}.
  - Enqueue on Br_Dectected if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the entry is dropped and Upd_Drop=1 the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM (combinational Tbl_* outputs):
  - IDLE: if FIFO non-empty and !Fetch_Lookup, drive a read of the head index and go to READ. Otherwise stay.
  - READ: capture Tbl_RData into cnt_q, even if Fetch_Lookup is high this cycle (data belongs to the previous address). Compute new_cnt and go to WRITE.
  - WRITE: if !Fetch_Lookup, drive Tbl_En=1, Tbl_We=1, Tbl_Addr=head index, Tbl_WData=new_cnt; pop FIFO; go to IDLE. If Fetch_Lookup, hold in WRITE.
- Saturating counter:
  - taken: 00→01→10→11, and 11 stays 11.
  - not-taken: 11→10→01→00, and 00 stays 00.
- Update throughput: at most one update every 3 port-free cycles.
- Lookup/update collision on the same index in flight: the lookup returns the stale counter. This is acceptable; no forwarding.
- Simultaneous Fetch_Lookup, Br_Dectected and pop are all legal in one cycle.

Test Plan:
- Reset with rst=1 for 2 cycles: Ghr=0, Queue_Full=0, Busy=0, Pred_Valid=0, all Tbl_* low.
- Resolve taken at Br_Index=0x05, fetch idle, table[5]=01 → read at cycle+1, write 10 to addr 0x05 at cycle+3, Busy drops at cycle+4. Ghr=0x80.
- Fetch_Lookup held high for 6 cycles with 2 queued updates → no Tbl_We during that window; updates complete afterwards in FIFO order. Pred_Valid=1 on cycles 2-7.
- Five Br_Dectected back-to-back with fetch always high → Queue_Full=1 after the 4th; the 5th gives Upd_Drop=1 for one cycle. Ghr shifted 5 times.
- Saturation: table[0x10]=11, two taken updates → stays 11. table[0x11]=00, not-taken → stays 00.
- rst asserted while in WRITE with Fetch_Lookup=1 → no write issued; FIFO empty and FSM IDLE next cycle.

Source files
------------

// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler.
// Owns the single-port 2-bit-counter pattern table and the global history
// register. Fetch lookups always get the table port. Resolved branches are
// queued and applied later as read-modify-write updates in idle port cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   Fetch_Lookup      fetch wants a prediction (table read at Ghr)
//   Br_PredictedBit   Tbl_RData[1], meaningful when Pred_Valid=1
//   Pred_Valid        registered, high the cycle after a lookup
//   Br_Dectected      branch resolved this cycle
//   Br_Comp_Result    resolved outcome (1 = taken)
//   Br_Index          table index the branch was predicted with
//   Ghr               current global history
//   Tbl_En/We/Addr/WData, Tbl_RData   pattern-table SRAM port
//   Queue_Full        update FIFO holds FIFO_DEPTH entries
//   Upd_Drop          registered pulse: resolved branch discarded (queue full)
//   Busy              FIFO non-empty or update FSM not idle
//
// state | meaning
// IDLE  | waiting for a queued update and a free port; issues head read
// READ  | read data of head index arrives; captured into cnt_q
// WRITE | waiting for a free port to write the updated counter and pop
module bp_update_scheduler #(
    parameter int GHR_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Fetch_Lookup,
    output logic                 Br_PredictedBit,
    output logic                 Pred_Valid,
    input  logic                 Br_Dectected,
    input  logic                 Br_Comp_Result,
    input  logic [GHR_WIDTH-1:0] Br_Index,
    output logic [GHR_WIDTH-1:0] Ghr,
    output logic                 Tbl_En,
    output logic                 Tbl_We,
    output logic [GHR_WIDTH-1:0] Tbl_Addr,
    output logic [1:0]           Tbl_WData,
    input  logic [1:0]           Tbl_RData,
    output logic                 Queue_Full,
    output logic                 Upd_Drop,
    output logic                 Busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [GHR_WIDTH-1:0] ghr_q;
    logic                 pred_valid_q;
    logic                 drop_q;
    logic [1:0]           cnt_q;
    logic [1:0]           new_cnt;

    // FIFO entry = {index, taken}
    logic [GHR_WIDTH:0]   fifo_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;

    logic                 pop, push;
    logic [GHR_WIDTH-1:0] head_idx;
    logic                 head_taken;

    assign head_idx   = fifo_q[rd_ptr_q][GHR_WIDTH:1];
    assign head_taken = fifo_q[rd_ptr_q][0];

    // A full queue can still accept when the head is popped in the same cycle.
    assign push = Br_Dectected && ((count_q < DEPTH_C) || pop);

    always_comb begin
        if (head_taken)
            new_cnt = (cnt_q == 2'b11) ? 2'b11 : cnt_q + 2'd1;
        else
            new_cnt = (cnt_q == 2'b00) ? 2'b00 : cnt_q - 2'd1;
    end

    always_comb begin
        state_d   = state_q;
        Tbl_En    = 1'b0;
        Tbl_We    = 1'b0;
        Tbl_Addr  = '0;
        Tbl_WData = 2'b00;
        pop       = 1'b0;

        if (Fetch_Lookup) begin
            Tbl_En   = 1'b1;
            Tbl_Addr = ghr_q;
        end

        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !Fetch_Lookup) begin
                    Tbl_En   = 1'b1;
                    Tbl_Addr = head_idx;
                    state_d  = READ;
                end
            end
            READ: state_d = WRITE;
            WRITE: begin
                if (!Fetch_Lookup) begin
                    Tbl_En    = 1'b1;
                    Tbl_We    = 1'b1;
                    Tbl_Addr  = head_idx;
                    Tbl_WData = new_cnt;
                    pop       = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Keep the port quiet during reset so an in-flight update never
        // produces a partial write.
        if (rst) begin
            Tbl_En    = 1'b0;
            Tbl_We    = 1'b0;
            Tbl_Addr  = '0;
            Tbl_WData = 2'b00;
            pop       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            cnt_q        <= 2'b00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pred_valid_q <= Fetch_Lookup;
            drop_q       <= Br_Dectected && !push;
            if (Br_Dectected)
                ghr_q <= {Br_Comp_Result, ghr_q[GHR_WIDTH-1:1]};
            // Read data always belongs to the address issued in IDLE.
            if (state_q == READ)
                cnt_q <= Tbl_RData;
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)
                count_q <= count_q + CW'(1);
            else if (pop && !push)
                count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            fifo_q[wr_ptr_q] <= {Br_Index, Br_Comp_Result};
    end

    assign Ghr             = ghr_q;
    assign Pred_Valid      = pred_valid_q;
    assign Br_PredictedBit = Tbl_RData[1];
    assign Upd_Drop        = drop_q;
    assign Queue_Full      = (count_q == DEPTH_C);
    assign Busy            = (count_q != '0) || (state_q != IDLE);

endmodule
